// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder with one full-adder cell and a carry flop.
// Define SERIAL_ADDER_OVF_EN to add the registered two's-complement overflow output ovf.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic carry_q, carry_d, cout_q, cout_d, s, c_nxt;
`ifdef SERIAL_ADDER_OVF_EN
   logic ovf_q, ovf_d;
`endif
   always_comb begin
      s = a_q[0] ^ b_q[0] ^ carry_q;
      c_nxt = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
      state_d = state_q;
      a_d = a_q;
      b_d = b_q;
      acc_d = acc_q;
      sum_d = sum_q;
      cnt_d = cnt_q;
      carry_d = carry_q;
      cout_d = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d = ovf_q;
`endif
      if (state_q == RUN) begin
         a_d = a_q >> 1;
         b_d = b_q >> 1;
         carry_d = c_nxt;
         acc_d = {s, acc_q[WIDTH-1:1]};
         cnt_d = cnt_q + 1'b1;
         // The final step publishes the result; until then sum/cout keep the previous one.
         if (cnt_q == CW'(WIDTH - 1)) begin
            sum_d = {s, acc_q[WIDTH-1:1]};
            cout_d = c_nxt;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_d = carry_q ^ c_nxt;
`endif
            state_d = DONE;
         end
      end else if (start) begin
         a_d = a;
         b_d = b;
         carry_d = cin;
         cnt_d = '0;
         state_d = RUN;
      end else begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q <= '0;
         b_q <= '0;
         acc_q <= '0;
         sum_q <= '0;
         cnt_q <= '0;
         carry_q <= 1'b0;
         cout_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q <= a_d;
         b_q <= b_d;
         acc_q <= acc_d;
         sum_q <= sum_d;
         cnt_q <= cnt_d;
         carry_q <= carry_d;
         cout_q <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q <= ovf_d;
`endif
      end
   end
   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign sum = sum_q;
   assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of serial_adder at WIDTH=8 and exhaustive WIDTH=3.
module tb_serial_adder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8;
   logic [7:0] a8 = '0, b8 = '0, sum8;
   logic start3 = 1'b0, cin3 = 1'b0, busy3, done3, cout3;
   logic [2:0] a3 = '0, b3 = '0, sum3;
`ifdef SERIAL_ADDER_OVF_EN
   logic ovf8, ovf3;
`endif
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
      , .ovf(ovf8)
`endif
   );

   serial_adder #(.WIDTH(3)) u3 (
      .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .cin(cin3),
      .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
`ifdef SERIAL_ADDER_OVF_EN
      , .ovf(ovf3)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic ci);
      int n;
      logic [8:0] e;
      e = {1'b0, av} + {1'b0, bv} + {8'd0, ci};
      a8 = av;
      b8 = bv;
      cin8 = ci;
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      chk("busy_after_accept", busy8, 1);
      n = 0;
      while (!done8 && n < 20) begin
         chk("busy_not_done", done8 & busy8, 0);
         tick();
         n++;
      end
      chk("latency", n, 8);
      chk("done_busy_low", busy8, 0);
      chk("sum", sum8, e[7:0]);
      chk("cout", cout8, e[8]);
`ifdef SERIAL_ADDER_OVF_EN
      chk("ovf", ovf8, (av[7] == bv[7]) && (e[7] != av[7]));
`endif
   endtask

   initial begin
      int dn, k, cyc, last;
      logic [7:0] va[4], vb[4];
      logic [8:0] ex[4];
      va = '{8'h12, 8'hF0, 8'h80, 8'h3C};
      vb = '{8'h34, 8'h20, 8'h80, 8'h0F};
      ex = '{9'h046, 9'h110, 9'h100, 9'h04B};
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("rst_busy", busy8, 0);
      chk("rst_done", done8, 0);
      chk("rst_sum", sum8, 8'h00);
      chk("rst_cout", cout8, 0);
`ifdef SERIAL_ADDER_OVF_EN
      chk("rst_ovf", ovf8, 0);
`endif
      op8(8'hFF, 8'h01, 1'b0);
      tick();
      op8(8'h7F, 8'h01, 1'b0);
      tick();
      op8(8'hA5, 8'h5A, 1'b1);
      tick();
      // start re-pulsed with junk operands during every busy cycle
      a8 = 8'h7F;
      b8 = 8'h01;
      cin8 = 1'b0;
      start8 = 1'b1;
      tick();
      a8 = 8'h11;
      b8 = 8'h11;
      dn = 0;
      for (int i = 0; i < 8; i++) begin
         if (i < 7) chk("ign_hold_sum", sum8, 8'h00);
         tick();
         if (i == 7) start8 = 1'b0;
         dn += int'(done8);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         dn += int'(done8);
      end
      chk("ign_done_count", dn, 1);
      chk("ign_sum", sum8, 8'h80);
      chk("ign_cout", cout8, 0);
      chk("ign_busy", busy8, 0);
      // reset sampled on the edge that ends the 4th RUN cycle
      a8 = 8'h0F;
      b8 = 8'h01;
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", busy8, 0);
      chk("abort_sum", sum8, 8'h00);
      chk("abort_cout", cout8, 0);
      dn = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         dn += int'(done8);
      end
      chk("abort_no_done", dn, 0);
      // continuous start, next operands presented in each DONE cycle
      a8 = va[0];
      b8 = vb[0];
      cin8 = 1'b0;
      start8 = 1'b1;
      tick();
      k = 0;
      cyc = 0;
      last = 0;
      while (k < 4 && cyc < 100) begin
         tick();
         cyc++;
         if (done8) begin
            chk("b2b_sum", sum8, ex[k][7:0]);
            chk("b2b_cout", cout8, ex[k][8]);
            chk("b2b_gap", cyc - last, k == 0 ? 8 : 9);
            last = cyc;
            k++;
            if (k < 4) begin
               a8 = va[k];
               b8 = vb[k];
            end else start8 = 1'b0;
         end else if (k > 0) begin
            chk("b2b_hold", {cout8, sum8}, ex[k-1]);
         end
      end
      chk("b2b_count", k, 4);
      start8 = 1'b0;
      tick();
      tick();
      for (int x = 0; x < 8; x++)
         for (int y = 0; y < 8; y++)
            for (int c = 0; c < 2; c++) begin
               int n;
               a3 = 3'(x);
               b3 = 3'(y);
               cin3 = 1'(c);
               start3 = 1'b1;
               tick();
               start3 = 1'b0;
               n = 0;
               while (!done3 && n < 10) begin
                  tick();
                  n++;
               end
               chk("w3_sum", {28'd0, cout3, sum3}, 32'(x + y + c));
            end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
